uart_rx_os16: RTL and testbench
===============================

// Module: uart_rx_os16
// PURPOSE
//  16x-oversampling UART receiver with majority-vote bit sampling, optional parity and framing checks.
//  Buffers received frames in a small FIFO and presents them on a valid/ready interface.
//  Forms the line-facing receive end of the UART; it accepts an external tx line and shares the 32-bit divisor convention.
// PARAMETERS
//  DATA_W      8   data bits per frame, sent LSB first
//  PARITY_EN   0   1 = a parity bit follows the data
//  PARITY_ODD  0   1 = odd parity, 0 = even; ignored when PARITY_EN=0
//  FIFO_DEPTH  4   receive FIFO entries; must be a power of 2, >=2
// PORTS
//  clk         in   1        system clock
//  reset       in   1        asynchronous, active-low reset
//  divisor     in   32       clk cycles per oversample tick (= f_clk/(16*baud)); 0 is treated as 1
//  rx          in   1        serial line, idles high, asynchronous to clk
//  out_data    out  DATA_W   head-of-FIFO data
//  out_perr    out  1        head entry had a parity error
//  out_ferr    out  1        head entry had a framing error (stop bit = 0)
//  out_valid   out  1        FIFO not empty
//  out_ready   in   1        consumer accepts the head entry when out_valid && out_ready
//  overrun     out  1        one-cycle pulse: a frame was dropped because the FIFO was full
//  busy        out  1        receive FSM is not in IDLE
// BEHAVIOUR
//  Reset (reset=0): all outputs 0; FIFO empty; FSM in IDLE; tick counter at 0; synchroniser FFs set to 1; armed=0.
//  rx passes through a 2-FF synchroniser (rx_s), adding 2 clk of latency.
//  Tick generator: down-counter loaded with max(divisor,1)-1; emits a 1-clk tick at 0, then reloads.
//  - A divisor change takes effect at the next reload.
//  os_cnt (4 bits) counts ticks within a bit and wraps 15->0; each bit period is 16 ticks.
//  Bit value = majority of rx_s at os_cnt 7, 8 and 9; the decision is taken on the tick where os_cnt=9.
//  FSM:
//  - IDLE: requires armed=1, which is set once rx_s=1 is seen on any tick.
//    On a tick with armed && rx_s=0: clear os_cnt to 0 and go to START.
//  - START: if the decision is 1 (false start), go to IDLE with armed unchanged. If 0, go to DATA at os_cnt 15->0.
//  - DATA: shift in DATA_W bits, LSB first. After the last bit go to PARITY if PARITY_EN, else STOP.
//  - PARITY: perr = received bit != expected (XOR of data, inverted when PARITY_ODD). Then go to STOP.
//  - STOP: ferr = (decision == 0). At the os_cnt=9 tick, push {perr,ferr,data} and go to IDLE.
//    Returning at mid-stop-bit allows resynchronisation on back-to-back frames.
//    If ferr=1, clear armed so a break (line held low) produces only one frame.
//  Push latency: the entry is visible on out_* one clk after the push cycle.
//  FIFO: pop when out_valid && out_ready.
//  - Full and push without pop: drop the frame, pulse overrun, FIFO contents unchanged.
//  - Full with push and pop in the same cycle: both occur, no overrun.
//  - Empty with push only: out_valid rises the next clk.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//  out_data, out_perr and out_ferr are undefined-but-stable (hold last) when out_valid=0.
//  Reset asserted mid-frame: the frame is lost and all state returns to reset values immediately.
//  After reset the receiver waits for rx high (armed) before accepting a start bit.
// STRUCTURE
//  Package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), OS_RATE=16, SAMPLE_LO=7, SAMPLE_HI=9.
//  Sub-module uart_sync_fifo (WIDTH, DEPTH): registered synchronous FIFO with push/pop/full/empty.
//  - Shared with a later TX buffer.
//  The tick generator, synchroniser and FSM live in uart_rx_os16.
// TESTING
//  1. divisor=4, 8N1, send 0xA5 with out_ready=1 -> out_data=0xA5, perr=0, ferr=0, one valid beat, overrun never asserted.
//  2. rx low for only 3 ticks, then high -> FSM returns to IDLE after the START decision, out_valid stays 0.
//  3. Frame 0x3C with stop bit 0 -> out_ferr=1, out_data=0x3C.
//     Then hold rx=0 for 40 bit times -> no further frames until rx returns high.
//  4. PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 1 -> perr=0; with parity 0 -> perr=1.
//  5. out_ready=0, send 5 frames 0x01..0x05 (FIFO_DEPTH=4) -> overrun pulses once on frame 5.
//     Draining yields 0x01..0x04.
//  6. Assert reset at DATA bit 3 -> busy=0 and out_valid=0 immediately; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receive FSM states, the
// oversampling rate and the sample window used for majority-vote decisions.
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int OS_RATE   = 16;                // ticks per bit period
   localparam int OS_W      = $clog2(OS_RATE);   // width of the in-bit tick counter
   localparam int SAMPLE_LO = 7;                 // first vote sample
   localparam int SAMPLE_HI = 9;                 // last vote sample, decision tick

   // 2-of-3 vote; tolerates a single corrupted sample near mid-bit.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Small synchronous first-word-fall-through FIFO. The head entry is presented
// combinationally from the storage registers, so a push into an empty FIFO is
// visible on head_data one clock later.
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset (pointers and storage cleared)
//   push       write push_data (ignored when full unless a pop happens too)
//   push_data  entry to write
//   pop        remove the head entry (ignored when empty)
//   head_data  current head entry (stale but stable when empty)
//   full       DEPTH entries stored
//   empty      no entries stored
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   // One extra pointer bit distinguishes full from empty when the addresses match.
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                    (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mem
         logic [WIDTH-1:0] entry_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
               entry_reg <= push_data;
            end
         end

         assign mem_q[gi] = entry_reg;
      end
   endgenerate

   assign head_data = mem_q[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

endmodule

// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16
// 16x-oversampling UART receiver. Each bit is decided by a 2-of-3 vote of the
// synchronised line at oversample positions 7, 8 and 9. Received frames carry
// parity/framing flags and are buffered in a small FIFO behind a valid/ready
// interface.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   divisor    clk cycles per oversample tick (0 behaves as 1)
//   rx         serial line, idles high, asynchronous to clk
//   out_data   head-of-FIFO data
//   out_perr   head entry had a parity error
//   out_ferr   head entry had a framing error
//   out_valid  FIFO not empty
//   out_ready  consumer takes the head entry when out_valid && out_ready
//   overrun    one-cycle pulse when a frame was dropped on a full FIFO
//   busy       receive FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
   parameter int DATA_W     = 8,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       divisor,
   input  logic              rx,
   output logic [DATA_W-1:0] out_data,
   output logic              out_perr,
   output logic              out_ferr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic              busy
);

   import uart_pkg::*;

   localparam int BC_W = $clog2(DATA_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
   localparam int FW = DATA_W + 2;   // {perr, ferr, data}

   // ---------------- synchroniser ----------------
   logic rx_meta_reg;
   logic rx_s_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_reg <= 1'b1;
         rx_s_reg    <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_s_reg    <= rx_meta_reg;
      end
   end

   // ---------------- tick generator ----------------
   // Divisor is only sampled at reload, so a change never truncates a tick period.
   logic [31:0] tick_cnt_reg;
   logic [31:0] reload_val;
   logic        tick;

   assign reload_val = (divisor == 32'd0) ? 32'd0 : (divisor - 32'd1);
   assign tick       = (tick_cnt_reg == 32'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt_reg <= 32'd0;
      end else begin
         tick_cnt_reg <= tick ? reload_val : (tick_cnt_reg - 32'd1);
      end
   end

   // ---------------- sampling ----------------
   logic [OS_W-1:0] os_cnt_reg;
   logic [OS_W-1:0] os_cnt_next;
   logic [1:0]      samp_reg;      // votes taken at SAMPLE_LO and SAMPLE_LO+1
   logic            at_sample;
   logic            at_wrap;
   logic            decision;

   assign at_sample = tick && (os_cnt_reg == OS_W'(SAMPLE_HI));
   assign at_wrap   = tick && (os_cnt_reg == OS_W'(OS_RATE - 1));
   assign decision  = majority3(samp_reg[0], samp_reg[1], rx_s_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         samp_reg <= 2'b00;
      end else if (tick) begin
         if (os_cnt_reg == OS_W'(SAMPLE_LO))     samp_reg[0] <= rx_s_reg;
         if (os_cnt_reg == OS_W'(SAMPLE_LO + 1)) samp_reg[1] <= rx_s_reg;
      end
   end

   // ---------------- receive FSM ----------------
   rx_state_t         state_reg,  state_next;
   logic              armed_reg,  armed_next;
   logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
   logic [DATA_W-1:0] shift_reg,  shift_next;
   logic              perr_reg,   perr_next;
   logic              push;
   logic              push_ferr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         os_cnt_reg  <= '0;
         armed_reg   <= 1'b0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         perr_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         os_cnt_reg  <= os_cnt_next;
         armed_reg   <= armed_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         perr_reg    <= perr_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      os_cnt_next  = tick ? (os_cnt_reg + OS_W'(1)) : os_cnt_reg;
      armed_next   = armed_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      perr_next    = perr_reg;
      push         = 1'b0;
      push_ferr    = 1'b0;

      // Any idle-level tick arms the receiver (recovery after reset or break).
      if (tick && rx_s_reg) armed_next = 1'b1;

      case (state_reg)
         IDLE: begin
            if (tick && armed_reg && !rx_s_reg) begin
               os_cnt_next = '0;
               state_next  = START;
            end
         end
         START: begin
            if (at_sample && decision) begin
               state_next = IDLE;             // glitch, not a start bit
            end else if (at_wrap) begin
               state_next   = DATA;
               bit_cnt_next = '0;
               perr_next    = 1'b0;
            end
         end
         DATA: begin
            if (at_sample) begin
               // LSB first: new bits enter at the top and move down.
               shift_next           = shift_reg >> 1;
               shift_next[DATA_W-1] = decision;
            end
            if (at_wrap) begin
               if (bit_cnt_reg == LAST_BIT) begin
                  state_next = PARITY_EN ? PARITY : STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BC_W'(1);
               end
            end
         end
         PARITY: begin
            if (at_sample) perr_next = decision != ((^shift_reg) ^ PARITY_ODD);
            if (at_wrap)   state_next = STOP;
         end
         STOP: begin
            // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
            if (at_sample) begin
               push       = 1'b1;
               push_ferr  = !decision;
               state_next = IDLE;
               // A held-low line must read high before another frame can start.
               if (!decision) armed_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- receive FIFO ----------------
   logic [FW-1:0] head_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          overrun_reg;

   assign pop = out_valid && out_ready;

   uart_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({perr_reg, push_ferr, shift_reg}),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Registered so the pulse lines up with the cycle a pushed entry would appear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun_reg <= 1'b0;
      end else begin
         overrun_reg <= push && fifo_full && !pop;
      end
   end

   assign out_valid = !fifo_empty;
   assign out_data  = head_data[DATA_W-1:0];
   assign out_ferr  = head_data[DATA_W];
   assign out_perr  = head_data[DATA_W+1];
   assign overrun   = overrun_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os16
// Two receivers share clock/reset/divisor: dut_n is 8N1, dut_p is 8E1.
// The bench serialises frames at 16*divisor clocks per bit and records what
// each frame must decode to; a compare process checks every accepted beat.
// -----------------------------------------------------------------------------
module tb_uart_rx_os16;

   localparam int DIV     = 4;
   localparam int BIT_CLK = 16 * DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] divisor = 32'(DIV);

   logic       rx_n = 1'b1, rx_p = 1'b1;
   logic [7:0] out_data_n, out_data_p;
   logic       out_perr_n, out_perr_p, out_ferr_n, out_ferr_p;
   logic       out_valid_n, out_valid_p;
   logic       out_ready_n = 1'b1, out_ready_p = 1'b1;
   logic       overrun_n, overrun_p, busy_n, busy_p;

   always #5 clk = ~clk;

   uart_rx_os16 #(.DATA_W(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .FIFO_DEPTH(4)) dut_n (
      .clk(clk), .reset(reset), .divisor(divisor), .rx(rx_n),
      .out_data(out_data_n), .out_perr(out_perr_n), .out_ferr(out_ferr_n),
      .out_valid(out_valid_n), .out_ready(out_ready_n), .overrun(overrun_n), .busy(busy_n));

   uart_rx_os16 #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .FIFO_DEPTH(4)) dut_p (
      .clk(clk), .reset(reset), .divisor(divisor), .rx(rx_p),
      .out_data(out_data_p), .out_perr(out_perr_p), .out_ferr(out_ferr_p),
      .out_valid(out_valid_p), .out_ready(out_ready_p), .overrun(overrun_p), .busy(busy_p));

   int total = 0;
   int bad   = 0;

   // Expected entries {perr, ferr, data}, oldest first.
   logic [9:0] exp_n[$];
   logic [9:0] exp_p[$];
   logic [9:0] last_n = '0, last_p = '0;
   int         pop_n = 0, pop_p = 0, ovr_n = 0, ovr_p = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", name, got, want);
      end
   endtask

   // What a frame must decode to, straight from the bits put on the line.
   function automatic logic [9:0] expect_entry(input logic [7:0] d, input bit has_par,
                                               input bit par, input bit odd, input bit stop);
      logic perr;
      perr = has_par ? (par != ((^d) ^ odd)) : 1'b0;
      return {perr, ~stop, d};
   endfunction

   // Compare process: every accepted beat must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid_n && out_ready_n) begin
            pop_n++;
            last_n = {out_perr_n, out_ferr_n, out_data_n};
            $display("rx_n beat: data=%02h perr=%0b ferr=%0b", out_data_n, out_perr_n, out_ferr_n);
            if (exp_n.size() == 0) check("rx_n_unexpected_beat", 32'(last_n), 32'h0);
            else check("rx_n_beat", 32'(last_n), 32'(exp_n.pop_front()));
         end
         if (out_valid_p && out_ready_p) begin
            pop_p++;
            last_p = {out_perr_p, out_ferr_p, out_data_p};
            $display("rx_p beat: data=%02h perr=%0b ferr=%0b", out_data_p, out_perr_p, out_ferr_p);
            if (exp_p.size() == 0) check("rx_p_unexpected_beat", 32'(last_p), 32'h0);
            else check("rx_p_beat", 32'(last_p), 32'(exp_p.pop_front()));
         end
         if (overrun_n) ovr_n++;
         if (overrun_p) ovr_p++;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx_p = v;
      else     rx_n = v;
   endtask

   // Leaves the line at the stop-bit level when done.
   task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                             input bit par, input bit stop, input bit keep);
      if (keep) begin
         if (sel) exp_p.push_back(expect_entry(d, has_par, par, 1'b0, stop));
         else     exp_n.push_back(expect_entry(d, has_par, par, 1'b0, stop));
      end
      set_rx(sel, 1'b0);
      wait_clk(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, d[i]);
         wait_clk(BIT_CLK);
      end
      if (has_par) begin
         set_rx(sel, par);
         wait_clk(BIT_CLK);
      end
      set_rx(sel, stop);
      wait_clk(BIT_CLK);
   endtask

   initial begin
      int p0, o0, n;
      logic [7:0] v;

      // ---- reset state ----
      #12;
      check("rst_valid_n", 32'(out_valid_n), 32'h0);
      check("rst_busy_n", 32'(busy_n), 32'h0);
      check("rst_overrun_n", 32'(overrun_n), 32'h0);
      check("rst_data_n", 32'(out_data_n), 32'h0);
      check("rst_valid_p", 32'(out_valid_p), 32'h0);
      check("rst_busy_p", 32'(busy_p), 32'h0);
      @(negedge clk) reset = 1'b1;
      wait_clk(2 * BIT_CLK);

      // ---- 1: plain 8N1 frame ----
      p0 = pop_n; o0 = ovr_n;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_clk(BIT_CLK);
      check("t1_beats", 32'(pop_n - p0), 32'd1);
      check("t1_no_overrun", 32'(ovr_n - o0), 32'd0);
      check("t1_entry", 32'(last_n), 32'h0A5);
      check("t1_queue_empty", 32'(exp_n.size()), 32'd0);

      // ---- 2: false start ----
      p0 = pop_n;
      rx_n = 1'b0;
      wait_clk(3 * DIV);
      rx_n = 1'b1;
      n = 0;
      @(negedge clk);
      while (!busy_n && n < 100) begin @(negedge clk); n++; end
      check("t2_busy_rise", 32'(busy_n), 32'h1);
      n = 0;
      while (busy_n && n < 200) begin @(negedge clk); n++; end
      check("t2_busy_fall", 32'(busy_n), 32'h0);
      wait_clk(2 * BIT_CLK);
      check("t2_no_valid", 32'(out_valid_n), 32'h0);
      check("t2_no_beat", 32'(pop_n - p0), 32'd0);

      // ---- 3: framing error then break ----
      p0 = pop_n;
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_clk(40 * BIT_CLK);
      @(negedge clk);
      check("t3_idle_in_break", 32'(busy_n), 32'h0);
      check("t3_one_beat", 32'(pop_n - p0), 32'd1);
      check("t3_entry", 32'(last_n), 32'h13C);
      rx_n = 1'b1;
      wait_clk(2 * BIT_CLK);
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_clk(BIT_CLK);
      check("t3_recover_entry", 32'(last_n), 32'h081);
      check("t3_beats", 32'(pop_n - p0), 32'd2);

      // ---- 4: even parity ----
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_clk(BIT_CLK);
      check("t4_parity_ok", 32'(last_p), 32'h007);
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
      wait_clk(BIT_CLK);
      check("t4_parity_bad", 32'(last_p), 32'h207);
      check("t4_beats", 32'(pop_p), 32'd2);

      // ---- 5: overrun on a full FIFO ----
      out_ready_n = 1'b0;
      p0 = pop_n; o0 = ovr_n;
      for (int i = 1; i <= 4; i++) begin
         v = 8'(i);
         send_frame(1'b0, v, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      check("t5_no_overrun_yet", 32'(ovr_n - o0), 32'd0);
      send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_clk(BIT_CLK);
      check("t5_overrun_once", 32'(ovr_n - o0), 32'd1);
      check("t5_valid_held", 32'(out_valid_n), 32'h1);
      out_ready_n = 1'b1;
      wait_clk(20);
      check("t5_drain_beats", 32'(pop_n - p0), 32'd4);
      check("t5_last", 32'(last_n), 32'h004);
      check("t5_queue_empty", 32'(exp_n.size()), 32'd0);

      // ---- 6: reset in the middle of a frame ----
      out_ready_n = 1'b0;
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_clk(BIT_CLK);
      check("t6_valid_before", 32'(out_valid_n), 32'h1);
      v = 8'h5A;
      rx_n = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < 3; i++) begin
         rx_n = v[i];
         wait_clk(BIT_CLK);
      end
      rx_n = v[3];
      wait_clk(BIT_CLK / 2);
      @(negedge clk);
      check("t6_busy_before", 32'(busy_n), 32'h1);
      #2 reset = 1'b0;
      exp_n.delete();
      #1;
      check("t6_busy_reset", 32'(busy_n), 32'h0);
      check("t6_valid_reset", 32'(out_valid_n), 32'h0);
      check("t6_data_reset", 32'(out_data_n), 32'h0);
      rx_n = 1'b1;
      wait_clk(10);
      @(negedge clk) reset = 1'b1;
      wait_clk(2 * BIT_CLK);
      out_ready_n = 1'b1;
      wait_clk(4);
      check("t6_no_stale", 32'(out_valid_n), 32'h0);
      p0 = pop_n;
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_clk(BIT_CLK);
      check("t6_entry", 32'(last_n), 32'h05A);
      check("t6_beats", 32'(pop_n - p0), 32'd1);

      // ---- wrap-up ----
      check("end_queue_n", 32'(exp_n.size()), 32'd0);
      check("end_queue_p", 32'(exp_p.size()), 32'd0);
      check("end_overrun_p", 32'(ovr_p), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
